// File: rtl/jstk_spi_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// jstk_pkg
//   Shared definitions for the PmodJSTK SPI transaction controller:
//   FSM state encoding, command prefix, protocol byte count, byte-index names
//   for the returned frame, and the TX byte lookup.
// -----------------------------------------------------------------------------
package jstk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SS_SETUP,
        ST_SHIFT,
        ST_BYTE_GAP,
        ST_SS_HOLD,
        ST_DONE
    } jstk_state_e;

    // Fixed by the device protocol; not for override.
    localparam int NUM_BYTES = 5;

    localparam logic [5:0] JSTK_CMD_PREFIX = 6'b100000;

    // Position of each field in the returned 5-byte frame.
    localparam int IDX_XLO = 0;
    localparam int IDX_XHI = 1;
    localparam int IDX_YLO = 2;
    localparam int IDX_YHI = 3;
    localparam int IDX_BTN = 4;

    // Byte 0 carries the LED command; the remaining bytes are dummy zeros.
    function automatic logic [7:0] jstk_tx_byte(input logic [2:0] idx, input logic [1:0] led);
        return (idx == 3'd0) ? {JSTK_CMD_PREFIX, led} : 8'h00;
    endfunction

endpackage

// File: rtl/jstk_spi_ctrl_if.sv
// -----------------------------------------------------------------------------
// jstk_spi_ctrl_if
//   Bundles the request side (START/LED_CMD), the Pmod pins (SS/SCLK/MOSI/MISO)
//   and the result side (BUSY/DONE/X_POS/Y_POS/BUTTONS) of the controller.
//   slave  : the controller itself
//   master : whoever issues requests and plays the device
// -----------------------------------------------------------------------------
interface jstk_spi_ctrl_if;
    logic       START;
    logic [1:0] LED_CMD;
    logic       MISO;
    logic       SS;
    logic       SCLK;
    logic       MOSI;
    logic       BUSY;
    logic       DONE;
    logic [9:0] X_POS;
    logic [9:0] Y_POS;
    logic [2:0] BUTTONS;

    modport slave (
        input  START, LED_CMD, MISO,
        output SS, SCLK, MOSI, BUSY, DONE, X_POS, Y_POS, BUTTONS
    );

    modport master (
        output START, LED_CMD, MISO,
        input  SS, SCLK, MOSI, BUSY, DONE, X_POS, Y_POS, BUTTONS
    );
endinterface

// File: rtl/jstk_spi_ctrl_tick_gen.sv
// -----------------------------------------------------------------------------
// spi_tick_gen
//   Half-period timebase for SCLK. While EN is high the counter runs
//   0..CLK_DIV_HALF and TICK pulses for the cycle the count is CLK_DIV_HALF,
//   so ticks are CLK_DIV_HALF+1 cycles apart. While EN is low the counter is
//   held at 0, so the first tick after enabling is a full period away.
//   Ports: CLK, RST (async, active-high), EN, TICK.
// -----------------------------------------------------------------------------
module spi_tick_gen #(
    parameter int CLK_DIV_HALF = 487
) (
    input  logic CLK,
    input  logic RST,
    input  logic EN,
    output logic TICK
);
    localparam int CW = (CLK_DIV_HALF < 1) ? 1 : $clog2(CLK_DIV_HALF + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        TICK  = EN && (cnt_q == CW'(CLK_DIV_HALF));
        cnt_d = cnt_q + 1'b1;
        if (!EN || TICK) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/jstk_spi_ctrl.sv
// -----------------------------------------------------------------------------
// jstk_spi_ctrl
//   Runs one PmodJSTK SPI transaction per accepted START: drops SS, shifts
//   five bytes in SPI mode 0 with idle gaps between bytes, raises SS and
//   pulses DONE. Byte 0 carries the LED command; the returned frame is
//   decoded into X/Y position and buttons, which change only in the DONE cycle.
//   Ports: CLK, RST (async, active-high), bus (jstk_spi_ctrl_if.slave):
//     START/LED_CMD request, MISO in; SS/SCLK/MOSI pins; BUSY, DONE,
//     X_POS, Y_POS, BUTTONS results. All outputs come straight from flops.
// -----------------------------------------------------------------------------
module jstk_spi_ctrl
    import jstk_pkg::*;
#(
    parameter int CLK_DIV_HALF   = 487,
    parameter int SS_SETUP_TICKS = 2,
    parameter int BYTE_GAP_TICKS = 20
) (
    input logic            CLK,
    input logic            RST,
    jstk_spi_ctrl_if.slave bus
);
    // 8 bits x 2 SCLK edges per byte
    localparam int BIT_TICKS = 16;
    localparam int TMAX1 = (BYTE_GAP_TICKS > BIT_TICKS) ? BYTE_GAP_TICKS : BIT_TICKS;
    localparam int TMAX  = (SS_SETUP_TICKS > TMAX1) ? SS_SETUP_TICKS : TMAX1;
    localparam int CW    = $clog2(TMAX + 1);

    localparam logic [CW-1:0] SETUP_LAST = CW'(SS_SETUP_TICKS - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(BYTE_GAP_TICKS - 1);
    localparam logic [CW-1:0] BYTE_LAST  = CW'(BIT_TICKS - 1);
    localparam logic [2:0]    IDX_LAST   = 3'(NUM_BYTES - 1);

    jstk_state_e   state_q, state_d;
    logic [CW-1:0] tcnt_q, tcnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [1:0]    led_q, led_d;
    logic [7:0]    tx_q, tx_d;       // MOSI is tx_q[7]
    logic [6:0]    rx_sh_q, rx_sh_d; // first seven bits of the byte in flight
    logic [9:0]    xs_q, xs_d;       // staging for results, never visible
    logic [9:0]    ys_q, ys_d;
    logic [2:0]    bs_q, bs_d;
    logic          miso_s1_q, miso_s2_q;
    logic          ss_q, ss_d;
    logic          sclk_q, sclk_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [9:0]    x_q, x_d;
    logic [9:0]    y_q, y_d;
    logic [2:0]    btn_q, btn_d;

    logic          tick;
    logic          tick_en;
    logic [7:0]    rx_byte;
    logic [7:0]    nxt_byte;

    // Counter only runs while a transfer owns the bus.
    assign tick_en = (state_q != ST_IDLE) && (state_q != ST_DONE);

    spi_tick_gen #(
        .CLK_DIV_HALF(CLK_DIV_HALF)
    ) u_tick (
        .CLK (CLK),
        .RST (RST),
        .EN  (tick_en),
        .TICK(tick)
    );

    always_comb begin
        state_d  = state_q;
        tcnt_d   = tcnt_q;
        idx_d    = idx_q;
        led_d    = led_q;
        tx_d     = tx_q;
        rx_sh_d  = rx_sh_q;
        xs_d     = xs_q;
        ys_d     = ys_q;
        bs_d     = bs_q;
        ss_d     = ss_q;
        sclk_d   = sclk_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        x_d      = x_q;
        y_d      = y_q;
        btn_d    = btn_q;
        rx_byte  = {rx_sh_q, miso_s2_q};
        nxt_byte = jstk_tx_byte(idx_q + 3'd1, led_q);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (bus.START) begin
                    state_d = ST_SS_SETUP;
                    led_d   = bus.LED_CMD;
                    tx_d    = jstk_tx_byte(3'd0, bus.LED_CMD);
                    idx_d   = 3'd0;
                    tcnt_d  = '0;
                    ss_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end

            ST_SS_SETUP: begin
                if (tick) begin
                    tcnt_d = tcnt_q + 1'b1;
                    if (tcnt_q == SETUP_LAST) begin
                        tcnt_d  = '0;
                        state_d = ST_SHIFT;
                    end
                end
            end

            ST_SHIFT: begin
                if (tick) begin
                    sclk_d = ~sclk_q;
                    tcnt_d = tcnt_q + 1'b1;
                    // Falling edge: sample MISO at the end of the high phase.
                    if (sclk_q) begin
                        rx_sh_d = {rx_sh_q[5:0], miso_s2_q};
                        tx_d    = {tx_q[6:0], 1'b0};
                        if (tcnt_q == BYTE_LAST) begin
                            tcnt_d = '0;
                            case (idx_q)
                                3'(IDX_XLO): xs_d[7:0] = rx_byte;
                                3'(IDX_XHI): xs_d[9:8] = rx_byte[1:0];
                                3'(IDX_YLO): ys_d[7:0] = rx_byte;
                                3'(IDX_YHI): ys_d[9:8] = rx_byte[1:0];
                                default:     bs_d      = rx_byte[2:0];
                            endcase
                            if (idx_q < IDX_LAST) begin
                                state_d = ST_BYTE_GAP;
                                tx_d    = nxt_byte;
                            end else begin
                                state_d = ST_SS_HOLD;
                                tx_d    = 8'h00;
                            end
                        end
                    end
                end
            end

            ST_BYTE_GAP: begin
                if (tick) begin
                    tcnt_d = tcnt_q + 1'b1;
                    if (tcnt_q == GAP_LAST) begin
                        tcnt_d  = '0;
                        idx_d   = idx_q + 3'd1;
                        state_d = ST_SHIFT;
                    end
                end
            end

            ST_SS_HOLD: begin
                if (tick) begin
                    tcnt_d = tcnt_q + 1'b1;
                    if (tcnt_q == SETUP_LAST) begin
                        tcnt_d  = '0;
                        state_d = ST_DONE;
                        ss_d    = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        tx_d    = 8'h00;
                        // Publish the whole frame at once.
                        x_d     = xs_q;
                        y_d     = ys_q;
                        btn_d   = bs_q;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            tcnt_q    <= '0;
            idx_q     <= '0;
            led_q     <= '0;
            tx_q      <= '0;
            rx_sh_q   <= '0;
            xs_q      <= '0;
            ys_q      <= '0;
            bs_q      <= '0;
            miso_s1_q <= 1'b0;
            miso_s2_q <= 1'b0;
            ss_q      <= 1'b1;
            sclk_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            btn_q     <= '0;
        end else begin
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
            idx_q     <= idx_d;
            led_q     <= led_d;
            tx_q      <= tx_d;
            rx_sh_q   <= rx_sh_d;
            xs_q      <= xs_d;
            ys_q      <= ys_d;
            bs_q      <= bs_d;
            miso_s1_q <= bus.MISO;
            miso_s2_q <= miso_s1_q;
            ss_q      <= ss_d;
            sclk_q    <= sclk_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            x_q       <= x_d;
            y_q       <= y_d;
            btn_q     <= btn_d;
        end
    end

    assign bus.SS      = ss_q;
    assign bus.SCLK    = sclk_q;
    assign bus.MOSI    = tx_q[7];
    assign bus.BUSY    = busy_q;
    assign bus.DONE    = done_q;
    assign bus.X_POS   = x_q;
    assign bus.Y_POS   = y_q;
    assign bus.BUTTONS = btn_q;

endmodule
